// File: rtl/itcm_port_arbiter.sv
// Arbitrates the single ITCM read-write port between the core load-store path and the debug/boot loader.
// The core has fixed priority, the loader has a starvation cap, and the loader can lock the port for bursts.
module itcm_port_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lsu_req,
   input  logic                  lsu_we,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   output logic                  lsu_gnt,
   output logic                  lsu_stall,
   output logic                  lsu_rvalid,
   output logic [DATA_WIDTH-1:0] lsu_rdata,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   input  logic                  dbg_lock,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  itcm_we,
   output logic [ADDR_WIDTH-1:0] itcm_addr,
   output logic [DATA_WIDTH-1:0] itcm_wdata,
   input  logic [DATA_WIDTH-1:0] itcm_rdata
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] W_MAX = CW'(MAX_WAIT);

   typedef enum logic {
      SHARED,
      LOCKED
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_waitCnt;
   logic            r_rdValid;
   logic            r_rdOwnerDbg;
   logic            w_lsuGnt;
   logic            w_dbgGnt;

   // Grants are decided in the request cycle; reset suppresses every grant.
   always_comb begin
      w_lsuGnt = 1'b0;
      w_dbgGnt = 1'b0;
      if (!rst) begin
         if (r_state == LOCKED) begin
            w_dbgGnt = dbg_req;
         end else if (lsu_req && dbg_req) begin
            if (r_waitCnt == W_MAX) w_dbgGnt = 1'b1;
            else                    w_lsuGnt = 1'b1;
         end else begin
            w_lsuGnt = lsu_req;
            w_dbgGnt = dbg_req;
         end
      end
   end

   always_comb begin
      itcm_we    = 1'b0;
      itcm_addr  = '0;
      itcm_wdata = '0;
      if (w_lsuGnt) begin
         itcm_we    = lsu_we;
         itcm_addr  = lsu_addr;
         itcm_wdata = lsu_wdata;
      end else if (w_dbgGnt) begin
         itcm_we    = dbg_we;
         itcm_addr  = dbg_addr;
         itcm_wdata = dbg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= SHARED;
         r_waitCnt    <= '0;
         r_rdValid    <= 1'b0;
         r_rdOwnerDbg <= 1'b0;
      end else begin
         case (r_state)
            SHARED:  if (w_dbgGnt && dbg_lock) r_state <= LOCKED;
            LOCKED:  if (!dbg_lock)            r_state <= SHARED;
            default:                           r_state <= SHARED;
         endcase
         if (w_dbgGnt || !dbg_req)    r_waitCnt <= '0;
         else if (r_waitCnt != W_MAX) r_waitCnt <= r_waitCnt + CW'(1);
         // The owner tag lets alternating reads pipeline with one response per cycle.
         r_rdValid    <= (w_lsuGnt && !lsu_we) || (w_dbgGnt && !dbg_we);
         r_rdOwnerDbg <= w_dbgGnt;
      end
   end

   assign lsu_gnt    = w_lsuGnt;
   assign dbg_gnt    = w_dbgGnt;
   assign lsu_stall  = lsu_req && !w_lsuGnt && !rst;
   assign lsu_rvalid = r_rdValid && !r_rdOwnerDbg && !rst;
   assign dbg_rvalid = r_rdValid &&  r_rdOwnerDbg && !rst;
   assign lsu_rdata  = lsu_rvalid ? itcm_rdata : '0;
   assign dbg_rdata  = dbg_rvalid ? itcm_rdata : '0;

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// Directed-vector bench for itcm_port_arbiter with a small synchronous ITCM model.
module tb_itcm_port_arbiter;

   logic        clock = 1'b0;
   logic        rst;
   logic        lsu_req, lsu_we, dbg_req, dbg_we, dbg_lock;
   logic [11:0] lsu_addr, dbg_addr;
   logic [31:0] lsu_wdata, dbg_wdata;
   logic        lsu_gnt, lsu_stall, lsu_rvalid, dbg_gnt, dbg_rvalid, itcm_we;
   logic [31:0] lsu_rdata, dbg_rdata, itcm_wdata;
   logic [11:0] itcm_addr;
   logic [31:0] itcm_rdata;
   logic [31:0] mem [0:1023];
   int          checks = 0;
   int          failures = 0;

   itcm_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
      .clk(clock), .rst(rst),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_gnt(lsu_gnt), .lsu_stall(lsu_stall), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .itcm_we(itcm_we), .itcm_addr(itcm_addr), .itcm_wdata(itcm_wdata), .itcm_rdata(itcm_rdata)
   );

   always #5 clock = ~clock;

   // ITCM model: written words live in mem, a few fixed locations hold preset read data.
   always @(posedge clock) begin
      if (itcm_we) mem[itcm_addr[11:2]] <= itcm_wdata;
      case (itcm_addr)
         12'h010: itcm_rdata <= 32'hDEADBEEF;
         12'h200: itcm_rdata <= 32'hA5A5A5A5;
         12'h204: itcm_rdata <= 32'h5A5A5A5A;
         default: itcm_rdata <= mem[itcm_addr[11:2]];
      endcase
   end

   task automatic applyStimulus(input logic r, input logic lReq, input logic lWe,
                                input logic [11:0] lAddr, input logic [31:0] lData,
                                input logic dReq, input logic dWe, input logic [11:0] dAddr,
                                input logic [31:0] dData, input logic dLock);
      rst = r;
      lsu_req = lReq; lsu_we = lWe; lsu_addr = lAddr; lsu_wdata = lData;
      dbg_req = dReq; dbg_we = dWe; dbg_addr = dAddr; dbg_wdata = dData; dbg_lock = dLock;
      #3;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      applyStimulus(1, 1, 1, 12'h0, 32'h0, 1, 1, 12'h0, 32'h0, 0);
      nextCycle();
      applyStimulus(1, 1, 1, 12'h0, 32'h0, 1, 1, 12'h0, 32'h0, 0);
      checkOutput("rst_lsu_gnt", lsu_gnt, 0);
      checkOutput("rst_dbg_gnt", dbg_gnt, 0);
      checkOutput("rst_stall", lsu_stall, 0);
      checkOutput("rst_itcm_we", itcm_we, 0);
      nextCycle();

      // Reset values with no requests
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("reset_gnts", {lsu_gnt, dbg_gnt, lsu_rvalid, dbg_rvalid, itcm_we, lsu_stall}, 0);
      checkOutput("reset_rdata", lsu_rdata | dbg_rdata, 0);
      checkOutput("reset_itcm_addr", itcm_addr, 0);
      checkOutput("reset_itcm_wdata", itcm_wdata, 0);
      nextCycle();

      // 1: core read alone
      applyStimulus(0, 1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t1_lsu_gnt", lsu_gnt, 1);
      checkOutput("t1_itcm_addr", itcm_addr, 32'h010);
      checkOutput("t1_itcm_we", itcm_we, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t1_lsu_rvalid", lsu_rvalid, 1);
      checkOutput("t1_lsu_rdata", lsu_rdata, 32'hDEADBEEF);
      checkOutput("t1_dbg_rvalid", dbg_rvalid, 0);
      checkOutput("t1_dbg_rdata", dbg_rdata, 0);
      nextCycle();
      checkOutput("t1_rvalid_single", lsu_rvalid, 0);

      // 2: starvation cap, both writers contend for ten cycles
      for (int c = 0; c < 10; c++) begin
         applyStimulus(0, 1, 1, 12'h300, 32'h1, 1, 1, 12'h304, 32'h2, 0);
         checkOutput($sformatf("t2_lsu_gnt_c%0d", c), lsu_gnt, (c == 4 || c == 9) ? 0 : 1);
         checkOutput($sformatf("t2_dbg_gnt_c%0d", c), dbg_gnt, (c == 4 || c == 9) ? 1 : 0);
         checkOutput($sformatf("t2_stall_c%0d", c), lsu_stall, (c == 4 || c == 9) ? 1 : 0);
         checkOutput($sformatf("t2_itcm_addr_c%0d", c), itcm_addr,
                     (c == 4 || c == 9) ? 32'h304 : 32'h300);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("idle_itcm_zero", {20'h0, itcm_addr} | itcm_wdata, 0);
      nextCycle();

      // 3: locked burst; loader first waits out the cap, then holds the port
      for (int c = 0; c < 4; c++) begin
         applyStimulus(0, 1, 1, 12'h380, 32'h9, 1, 1, 12'h100, 32'h11111111, 1);
         checkOutput($sformatf("t3_pre_lsu_gnt_c%0d", c), lsu_gnt, 1);
         nextCycle();
      end
      applyStimulus(0, 1, 1, 12'h380, 32'h9, 1, 1, 12'h100, 32'h11111111, 1);
      checkOutput("t3_b1_dbg_gnt", dbg_gnt, 1);
      checkOutput("t3_b1_itcm_we", itcm_we, 1);
      checkOutput("t3_b1_stall", lsu_stall, 1);
      checkOutput("t3_b1_wdata", itcm_wdata, 32'h11111111);
      nextCycle();
      applyStimulus(0, 1, 1, 12'h380, 32'h9, 1, 1, 12'h104, 32'h22222222, 1);
      checkOutput("t3_b2_dbg_gnt", dbg_gnt, 1);
      checkOutput("t3_b2_itcm_we", itcm_we, 1);
      checkOutput("t3_b2_stall", lsu_stall, 1);
      checkOutput("t3_b2_addr", itcm_addr, 32'h104);
      nextCycle();
      applyStimulus(0, 1, 1, 12'h380, 32'h9, 1, 1, 12'h108, 32'h33333333, 0);
      checkOutput("t3_b3_dbg_gnt", dbg_gnt, 1);
      checkOutput("t3_b3_itcm_we", itcm_we, 1);
      checkOutput("t3_b3_stall", lsu_stall, 1);
      checkOutput("t3_b3_wdata", itcm_wdata, 32'h33333333);
      nextCycle();
      applyStimulus(0, 1, 0, 12'h104, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t3_after_lsu_gnt", lsu_gnt, 1);
      nextCycle();
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t3_readback", lsu_rdata, 32'h22222222);
      nextCycle();

      // 4: alternating reads from both owners
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 1, 0, 12'h200, 32'h0, 0);
      checkOutput("t4_dbg_gnt", dbg_gnt, 1);
      nextCycle();
      applyStimulus(0, 1, 0, 12'h204, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t4_lsu_gnt", lsu_gnt, 1);
      checkOutput("t4_n1_dbg_rvalid", dbg_rvalid, 1);
      checkOutput("t4_n1_dbg_rdata", dbg_rdata, 32'hA5A5A5A5);
      checkOutput("t4_n1_lsu_rvalid", lsu_rvalid, 0);
      checkOutput("t4_n1_lsu_rdata", lsu_rdata, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t4_n2_lsu_rvalid", lsu_rvalid, 1);
      checkOutput("t4_n2_lsu_rdata", lsu_rdata, 32'h5A5A5A5A);
      checkOutput("t4_n2_dbg_rvalid", dbg_rvalid, 0);
      checkOutput("t4_n2_dbg_rdata", dbg_rdata, 0);
      nextCycle();
      checkOutput("t4_n3_lsu_rvalid", lsu_rvalid, 0);

      // 6: loader write with core idle
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 1, 1, 12'h0FC, 32'hCAFEF00D, 0);
      checkOutput("t6_dbg_gnt", dbg_gnt, 1);
      checkOutput("t6_itcm_we", itcm_we, 1);
      checkOutput("t6_itcm_addr", itcm_addr, 32'h0FC);
      checkOutput("t6_itcm_wdata", itcm_wdata, 32'hCAFEF00D);
      nextCycle();
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t6_no_rvalid", {lsu_rvalid, dbg_rvalid}, 0);
      checkOutput("t6_wait_cnt", 32'(dut.r_waitCnt), 0);
      nextCycle();

      // 5: reset while locked with a loader read in flight
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 1, 1, 12'h0F8, 32'h7, 1);
      checkOutput("t5_lock_gnt", dbg_gnt, 1);
      nextCycle();
      applyStimulus(0, 1, 0, 12'h010, 32'h0, 1, 0, 12'h200, 32'h0, 1);
      checkOutput("t5_locked_read_gnt", dbg_gnt, 1);
      checkOutput("t5_locked_lsu_stall", lsu_stall, 1);
      nextCycle();
      applyStimulus(1, 1, 0, 12'h010, 32'h0, 1, 0, 12'h200, 32'h0, 1);
      checkOutput("t5_rst_dbg_gnt", dbg_gnt, 0);
      checkOutput("t5_rst_itcm_we", itcm_we, 0);
      checkOutput("t5_rst_stall", lsu_stall, 0);
      nextCycle();
      applyStimulus(0, 1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t5_post_dbg_rvalid", dbg_rvalid, 0);
      checkOutput("t5_post_dbg_rdata", dbg_rdata, 0);
      checkOutput("t5_post_lsu_gnt", lsu_gnt, 1);
      nextCycle();
      applyStimulus(0, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
      checkOutput("t5_post_read", lsu_rdata, 32'hDEADBEEF);
      nextCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/itcm_port_arbiter.md
Name: itcm_port_arbiter

Overview:
- Shares the single read-write port of the instruction memory (ITCM) between two requesters: the core load-store path (MEMEX stage) and an external debug/boot loader.
- Uses fixed priority to the core, a starvation cap for the loader, and a loader lock mode for uninterrupted burst writes.
- Sits between the MEMEX stage, the loader and the ITCM rw port.
- Drives the MEMEX stall when the core loses arbitration.

Parameters:
ADDR_WIDTH, 12, ITCM byte-address width (matches the ITCM rw address port)
DATA_WIDTH, 32, data word width
MAX_WAIT, 4, consecutive contested cycles the loader may lose before it is forced a grant (must be ≥1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
lsu_req  in  1  core requests port this cycle
lsu_we  in  1  1=write, 0=read
lsu_addr  in  ADDR_WIDTH  core address
lsu_wdata  in  DATA_WIDTH  core write data
lsu_gnt  out  1  core access accepted this cycle
lsu_stall  out  1  lsu_req & ~lsu_gnt; drives stall_MEMEX
lsu_rvalid  out  1  core read data valid
lsu_rdata  out  DATA_WIDTH  core read data
dbg_req  in  1  loader requests port
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_WIDTH  loader address
dbg_wdata  in  DATA_WIDTH  loader write data
dbg_lock  in  1  hold port after this grant
dbg_gnt  out  1  loader access accepted this cycle
dbg_rvalid  out  1  loader read data valid
dbg_rdata  out  DATA_WIDTH  loader read data
itcm_we  out  1  ITCM rw write enable
itcm_addr  out  ADDR_WIDTH  ITCM rw address
itcm_wdata  out  DATA_WIDTH  ITCM rw write data
itcm_rdata  in  DATA_WIDTH  ITCM rw read data (1-cycle synchronous)

Behaviour:
- Grants are combinational in the request cycle. At most one gnt is high per cycle.
- ITCM outputs mux the winner's we/addr/wdata. With no grant, itcm_we=0, itcm_addr=0 and itcm_wdata=0.
- States: SHARED (reset state) and LOCKED.
- SHARED arbitration:
  - Only one request present: grant it.
  - Both present: grant lsu, unless wait_cnt==MAX_WAIT, in which case grant dbg.
- wait_cnt (clog2(MAX_WAIT+1) bits) updates at each edge:
  - reset to 0 on dbg_gnt or ~dbg_req;
  - otherwise increment when dbg_req & ~dbg_gnt;
  - saturates at MAX_WAIT.
- SHARED→LOCKED at the edge ending a cycle with dbg_gnt & dbg_lock.
- LOCKED:
  - lsu_gnt=0 (so lsu_stall=lsu_req);
  - dbg_req is granted every cycle it is asserted;
  - LOCKED→SHARED at the edge ending any cycle with dbg_lock=0, whether or not dbg_req is high;
  - the core may be granted in the following cycle.
- Read response:
  - A granted read (we=0) in cycle N registers owner tag and valid.
  - In cycle N+1 the owner's rvalid=1 and its rdata=itcm_rdata; the other rvalid=0.
  - A non-owner rdata holds 0.
  - Granted writes produce no rvalid.
- Back-to-back reads from alternating owners are fully pipelined: one response per cycle, routed by tag, no bubbles.
- rst high in a cycle:
  - all gnt=0, itcm_we=0, lsu_stall=0 that cycle;
  - next cycle state=SHARED, wait_cnt=0, both rvalid=0 (an in-flight read response is squashed);
  - all rdata=0.
- Reset values (cycle after rst): lsu_gnt=dbg_gnt=0 absent requests, lsu_rvalid=dbg_rvalid=0, lsu_rdata=dbg_rdata=0, itcm_we=0, itcm_addr=0, itcm_wdata=0, lsu_stall=0.
- Address/data widths pass through unmodified. No alignment checking; misaligned addresses go to ITCM as given.

Test Plan:
1. Core read alone: lsu_req=1, lsu_we=0, lsu_addr=0x010; ITCM model returns 0xDEADBEEF. Required: lsu_gnt=1 and itcm_addr=0x010 same cycle; next cycle lsu_rvalid=1, lsu_rdata=0xDEADBEEF, dbg_rvalid=0.
2. Starvation cap (MAX_WAIT=4): both requests held continuously from cycle 0. Required: lsu granted cycles 0–3; dbg granted cycle 4 with lsu_stall=1; lsu granted cycles 5–8; dbg granted cycle 9; pattern repeats.
3. Locked burst: dbg writes 0x11111111, 0x22222222, 0x33333333 to 0x100, 0x104, 0x108 with dbg_lock=1 on beats 1–2 and 0 on beat 3, while lsu_req is held throughout. Required: dbg granted 3 consecutive cycles; itcm_we=1 each beat; lsu_stall=1 for those cycles; lsu_gnt=1 the cycle after beat 3.
4. Alternating reads: dbg read 0x200 (data 0xA5A5A5A5) in cycle N, lsu read 0x204 (data 0x5A5A5A5A) in cycle N+1, no contention. Required: dbg_rvalid=1 with 0xA5A5A5A5 in N+1; lsu_rvalid=1 with 0x5A5A5A5A in N+2; each rvalid single-cycle.
5. Reset mid-operation: enter LOCKED, issue a dbg read, assert rst the following cycle with dbg_req=1. Required: dbg_gnt=0 and itcm_we=0 during rst; dbg_rvalid=0 after rst; state SHARED (lsu_req alone is granted the first cycle after rst).
6. Loader alone with core idle: dbg write 0xCAFEF00D to 0x0FC. Required: dbg_gnt=1 and itcm_we=1 same cycle; no rvalid; wait_cnt stays 0.
